// File: rtl/rx_descrambler_lock_pkg.sv
// rx_descrambler_lock_pkg: shared sync-header codes, descrambler taps and lock FSM states
package rx_descrambler_lock_pkg;
    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;
    localparam int SCR_LEN = 58;
    localparam int TAP_A   = 38;
    localparam int TAP_B   = 57;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {HUNT, SLIP, WAIT, LOCKED} lock_state_t;

    function automatic logic hdr_bad(input logic [1:0] h);
        return h != SYNC_DATA && h != SYNC_CTRL;
    endfunction
endpackage

// File: rtl/rx_descrambler_lock_if.sv
// rx_descrambler_lock_if: per-lane receive bus between gearbox side and frame decoder side
interface rx_descrambler_lock_if
    import rx_descrambler_lock_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int DATA_WIDTH = 64
);
    logic [NUM_LANES*(DATA_WIDTH+2)-1:0] data_in;
    logic [NUM_LANES-1:0]                data_valid_in;
    logic                                bypass;
    logic                                err_cnt_clr;
    logic [NUM_LANES*DATA_WIDTH-1:0]     data_out;
    logic [NUM_LANES*2-1:0]              header_out;
    logic [NUM_LANES-1:0]                data_valid_out;
    logic [NUM_LANES-1:0]                block_lock;
    logic [NUM_LANES-1:0]                slip;
    logic [NUM_LANES*CNT_W-1:0]          hdr_err_cnt;

    modport master (
        output data_in, data_valid_in, bypass, err_cnt_clr,
        input  data_out, header_out, data_valid_out, block_lock, slip, hdr_err_cnt
    );
    modport slave (
        input  data_in, data_valid_in, bypass, err_cnt_clr,
        output data_out, header_out, data_valid_out, block_lock, slip, hdr_err_cnt
    );
endinterface

// File: rtl/rx_descrambler_lock_lane.sv
// rx_descrambler_lane: one lane of x^58+x^39+1 descrambler, sync-header block lock and error counter
module rx_descrambler_lane
    import rx_descrambler_lock_pkg::*;
#(
    parameter int                 DATA_WIDTH = 64,
    parameter logic [SCR_LEN-1:0] SEED       = 58'h3FF_FFFF_FFFF_FFFF,
    parameter int                 LOCK_CNT   = 64,
    parameter int                 WINDOW     = 64,
    parameter int                 UNLOCK_CNT = 16,
    parameter int                 SLIP_WAIT  = 16
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH+1:0] i_data,
    input  logic                  i_valid,
    input  logic                  i_bypass,
    input  logic                  i_clr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_hdr,
    output logic                  o_valid,
    output logic                  o_lock,
    output logic                  o_slip,
    output logic [CNT_W-1:0]      o_err_cnt
);
    lock_state_t           r_state, w_state;
    logic [SCR_LEN-1:0]    r_scr, w_scr;
    logic [DATA_WIDTH-1:0] r_data, w_desc;
    logic [1:0]            r_hdr;
    logic                  r_valid;
    logic [CNT_W-1:0]      r_cnt, w_cnt, r_bad, w_bad_cnt, r_err;
    logic                  w_bad, w_err_inc;

    assign w_bad     = hdr_bad(i_data[DATA_WIDTH+1:DATA_WIDTH]);
    assign w_err_inc = i_valid && w_bad && r_state != WAIT && r_err != '1;

    // the scrambled bit, not the recovered one, feeds the shift register
    always_comb begin
        w_scr  = r_scr;
        w_desc = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            w_desc[i] = i_data[i] ^ w_scr[TAP_A] ^ w_scr[TAP_B];
            w_scr     = {w_scr[SCR_LEN-2:0], i_data[i]};
        end
    end

    // r_cnt is the good-header run in HUNT, valid-word count in WAIT, window position in LOCKED
    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_bad_cnt = r_bad;
        case (r_state)
            HUNT: if (i_valid) begin
                if (w_bad) begin
                    w_state = SLIP;
                    w_cnt   = '0;
                end else if (r_cnt == CNT_W'(LOCK_CNT - 1)) begin
                    w_state   = LOCKED;
                    w_cnt     = '0;
                    w_bad_cnt = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            SLIP: begin
                w_state = WAIT;
                w_cnt   = '0;
            end
            WAIT: if (i_valid) begin
                w_state = r_cnt == CNT_W'(SLIP_WAIT - 1) ? HUNT : WAIT;
                w_cnt   = r_cnt == CNT_W'(SLIP_WAIT - 1) ? '0 : r_cnt + 1'b1;
            end
            LOCKED: if (i_valid) begin
                if (w_bad && r_bad == CNT_W'(UNLOCK_CNT - 1)) begin
                    w_state   = HUNT;
                    w_cnt     = '0;
                    w_bad_cnt = '0;
                end else if (r_cnt == CNT_W'(WINDOW - 1)) begin
                    w_cnt     = '0;
                    w_bad_cnt = '0;
                end else begin
                    w_cnt     = r_cnt + 1'b1;
                    w_bad_cnt = r_bad + CNT_W'(w_bad);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= HUNT;
            r_cnt   <= '0;
            r_bad   <= '0;
            r_scr   <= SEED;
            r_data  <= '0;
            r_hdr   <= '0;
            r_valid <= 1'b0;
            r_err   <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_bad   <= w_bad_cnt;
            r_valid <= i_valid;
            r_err   <= i_clr ? '0 : r_err + CNT_W'(w_err_inc);
            if (i_valid) begin
                r_scr  <= w_scr;
                r_data <= i_bypass ? i_data[DATA_WIDTH-1:0] : w_desc;
                r_hdr  <= i_data[DATA_WIDTH+1:DATA_WIDTH];
            end
        end
    end

    assign o_data    = r_data;
    assign o_hdr     = r_hdr;
    assign o_valid   = r_valid;
    assign o_lock    = r_state == LOCKED;
    assign o_slip    = r_state == SLIP;
    assign o_err_cnt = r_err;
endmodule

// File: rtl/rx_descrambler_lock.sv
// rx_descrambler_lock: multi-lane 64b/66b descrambler with per-lane block lock; the top only slices buses
module rx_descrambler_lock
    import rx_descrambler_lock_pkg::*;
#(
    parameter int                 NUM_LANES  = 4,
    parameter int                 DATA_WIDTH = 64,
    parameter logic [SCR_LEN-1:0] SEED       = 58'h3FF_FFFF_FFFF_FFFF,
    parameter int                 LOCK_CNT   = 64,
    parameter int                 WINDOW     = 64,
    parameter int                 UNLOCK_CNT = 16,
    parameter int                 SLIP_WAIT  = 16
)(
    input logic                  clk,
    input logic                  rst_n,
    rx_descrambler_lock_if.slave bus
);
    localparam int BW = DATA_WIDTH + 2;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        rx_descrambler_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .SEED       (SEED),
            .LOCK_CNT   (LOCK_CNT),
            .WINDOW     (WINDOW),
            .UNLOCK_CNT (UNLOCK_CNT),
            .SLIP_WAIT  (SLIP_WAIT)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_data    (bus.data_in[l*BW +: BW]),
            .i_valid   (bus.data_valid_in[l]),
            .i_bypass  (bus.bypass),
            .i_clr     (bus.err_cnt_clr),
            .o_data    (bus.data_out[l*DATA_WIDTH +: DATA_WIDTH]),
            .o_hdr     (bus.header_out[l*2 +: 2]),
            .o_valid   (bus.data_valid_out[l]),
            .o_lock    (bus.block_lock[l]),
            .o_slip    (bus.slip[l]),
            .o_err_cnt (bus.hdr_err_cnt[l*CNT_W +: CNT_W])
        );
    end
endmodule
